// File: rtl/tof_bit_sender_if.sv
// Upstream time-of-flight handshake: value/valid from the producer, ready back from the sender.
interface tof_bit_sender_if;
    logic [31:0] tof_value;
    logic        tof_valid;
    logic        tof_ready;

    modport master (output tof_value, output tof_valid, input  tof_ready);
    modport slave  (input  tof_value, input  tof_valid, output tof_ready);
endinterface

// File: rtl/tof_bit_sender.sv
// Serialises a captured time-of-flight count to an Arduino, LSB first, framed by start_wire.
// Define TOF_SENDER_PARITY_EN to append an even-parity bit after the data bits.
module tof_bit_sender #(
    parameter int unsigned BIT_CYCLES  = 10000,
    parameter int unsigned LEAD_CYCLES = 100000000,
    parameter int unsigned NUM_BITS    = 32
) (
    input  logic            clock,
    input  logic            reset,
    tof_bit_sender_if.slave tof,
    input  logic            arduino_ack,
    input  logic            abort,
    output logic            start_wire,
    output logic            data_wire,
    output logic            bit_strobe,
    output logic            done
);

`ifdef TOF_SENDER_PARITY_EN
    localparam int unsigned TOTAL_BITS = NUM_BITS + 1;
    localparam logic [31:0] DATA_MASK  = (NUM_BITS >= 32) ? '1 : ((32'd1 << NUM_BITS) - 32'd1);
`else
    localparam int unsigned TOTAL_BITS = NUM_BITS;
`endif
    localparam int unsigned TIMER_MAX  = (LEAD_CYCLES > BIT_CYCLES) ? LEAD_CYCLES : BIT_CYCLES;
    localparam int unsigned TW         = $clog2(TIMER_MAX);
    localparam int unsigned CW         = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;

    localparam logic [TW-1:0] LEAD_LOAD = TW'(LEAD_CYCLES - 1);
    localparam logic [TW-1:0] BIT_LOAD  = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] HALF      = TW'(BIT_CYCLES / 2);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [CW-1:0] LAST_IDX  = CW'(TOTAL_BITS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, WAIT_ACK} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic [31:0]   shift, shift_n;
    logic          start_n, data_n, done_n;
    logic          ack_s1, ack_s2;
`ifdef TOF_SENDER_PARITY_EN
    logic          parity, parity_n;
    localparam logic [CW-1:0] LAST_DATA_IDX = CW'(NUM_BITS - 1);
`endif

    assign tof.tof_ready = (state == IDLE);
    assign bit_strobe    = (state == SHIFT) && (timer < HALF);

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        start_n   = start_wire;
        data_n    = data_wire;
        done_n    = 1'b0;
`ifdef TOF_SENDER_PARITY_EN
        parity_n  = parity;
`endif
        if (abort) begin
            state_n   = IDLE;
            timer_n   = '0;
            bit_cnt_n = '0;
            start_n   = 1'b0;
            data_n    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tof.tof_valid) begin
                        shift_n = tof.tof_value;
`ifdef TOF_SENDER_PARITY_EN
                        parity_n = ^(tof.tof_value & DATA_MASK);
`endif
                        start_n = 1'b1;
                        timer_n = LEAD_LOAD;
                        state_n = LEAD;
                    end
                end
                LEAD: begin
                    if (timer == '0) begin
                        data_n    = shift[0];
                        timer_n   = BIT_LOAD;
                        bit_cnt_n = '0;
                        state_n   = SHIFT;
                    end else begin
                        timer_n = timer - TIMER_ONE;
                    end
                end
                SHIFT: begin
                    if (timer != '0) begin
                        timer_n = timer - TIMER_ONE;
                    end else if (bit_cnt == LAST_IDX) begin
                        start_n = 1'b0;
                        data_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = WAIT_ACK;
                    end else begin
                        // shift[1] is the bit that becomes shift[0] after this edge
                        shift_n   = {1'b0, shift[31:1]};
                        data_n    = shift[1];
                        bit_cnt_n = bit_cnt + CNT_ONE;
                        timer_n   = BIT_LOAD;
`ifdef TOF_SENDER_PARITY_EN
                        if (bit_cnt == LAST_DATA_IDX) data_n = parity;
`endif
                    end
                end
                WAIT_ACK: begin
                    if (ack_s2) state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                    start_n = 1'b0;
                    data_n  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            start_wire <= 1'b0;
            data_wire  <= 1'b0;
            done       <= 1'b0;
            ack_s1     <= 1'b0;
            ack_s2     <= 1'b0;
`ifdef TOF_SENDER_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            start_wire <= start_n;
            data_wire  <= data_n;
            done       <= done_n;
            ack_s1     <= arduino_ack;
            ack_s2     <= ack_s1;
`ifdef TOF_SENDER_PARITY_EN
            parity     <= parity_n;
`endif
        end
    end

endmodule

// File: tb/tb_tof_bit_sender.sv
// Scoreboard bench for tof_bit_sender: the driver queues expected bits/done cycles, the monitor checks them.
module tb_tof_bit_sender;

`ifdef TOF_SENDER_PARITY_EN
    localparam int FRAME = 4 + 33 * 4;
`else
    localparam int FRAME = 4 + 32 * 4;
`endif

    logic clock = 1'b0;
    logic reset;
    logic arduino_ack;
    logic abort;
    logic start_wire, data_wire, bit_strobe, done;

    tof_bit_sender_if tof_if ();

    tof_bit_sender #(
        .BIT_CYCLES (4),
        .LEAD_CYCLES(4),
        .NUM_BITS   (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tof        (tof_if),
        .arduino_ack(arduino_ack),
        .abort      (abort),
        .start_wire (start_wire),
        .data_wire  (data_wire),
        .bit_strobe (bit_strobe),
        .done       (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int   tests = 0;
    int   fails = 0;
    logic exp_bits[$];
    int   exp_done[$];
    logic mon_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising bit_strobe consumes one expected bit, every done consumes one expected cycle
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                mon_prev = 1'b0;
            end else begin
                if (bit_strobe && !mon_prev) begin
                    if (exp_bits.size() == 0) check("unexpected_bit", bit_strobe, 0);
                    else check("data_bit", data_wire, exp_bits.pop_front());
                end
                mon_prev = bit_strobe;
                if (done) begin
                    if (exp_done.size() == 0) check("unexpected_done", done, 0);
                    else check("done_cycle", cyc, exp_done.pop_front());
                    check("done_start_low", start_wire, 0);
                    check("done_data_low", data_wire, 0);
                end
            end
        end
    end

    task automatic accept(input logic [31:0] v, input bit keep_valid, output int acc);
        @(negedge clock);
        check("ready_before_accept", tof_if.tof_ready, 1);
        tof_if.tof_value = v;
        tof_if.tof_valid = 1'b1;
        @(posedge clock);
        #1;
        acc = cyc;
        if (!keep_valid) tof_if.tof_valid = 1'b0;
        check("start_after_accept", start_wire, 1);
        check("ready_low_after_accept", tof_if.tof_ready, 0);
    endtask

    task automatic push_frame(input logic [31:0] v, input int acc);
        for (int i = 0; i < 32; i++) exp_bits.push_back(v[i]);
`ifdef TOF_SENDER_PARITY_EN
        exp_bits.push_back(^v);
`endif
        exp_done.push_back(acc + FRAME);
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < max_cycles);
        if (!done) check("done_timeout", done, 1);
    endtask

    task automatic do_ack();
        int n = 0;
        @(negedge clock);
        check("ready_low_in_wait_ack", tof_if.tof_ready, 0);
        arduino_ack = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!tof_if.tof_ready && n < 10);
        tof_if.tof_valid = 1'b0;
        arduino_ack = 1'b0;
        tests++;
        if (!(n >= 2 && n <= 3)) begin
            fails++;
            $display("FAIL ack_latency: got %0d cycles, expected 2..3", n);
        end
    endtask

    initial begin
        int acc;
        reset = 1'b1;
        abort = 1'b0;
        arduino_ack = 1'b0;
        tof_if.tof_valid = 1'b0;
        tof_if.tof_value = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_ready", tof_if.tof_ready, 1);
        check("reset_start", start_wire, 0);
        check("reset_data", data_wire, 0);
        check("reset_strobe", bit_strobe, 0);
        check("reset_done", done, 0);

        // Alternating pattern, no parity-bit contribution (16 ones)
        accept(32'h5555_5555, 1'b0, acc);
        push_frame(32'h5555_5555, acc);
        wait_done(300);
        do_ack();

        // First and last data bits set
        accept(32'h8000_0001, 1'b0, acc);
        push_frame(32'h8000_0001, acc);
        wait_done(300);
        do_ack();

        // valid held high and value changed mid-frame: only 0x7 may go out
        accept(32'h0000_0007, 1'b1, acc);
        push_frame(32'h0000_0007, acc);
        repeat (20) @(negedge clock);
        tof_if.tof_value = 32'hFFFF_FFFF;
        @(negedge clock);
        check("ready_low_mid_frame", tof_if.tof_ready, 0);
        check("start_high_mid_frame", start_wire, 1);
        wait_done(300);
        do_ack();

        // Abort during bit 10: bits 0..10 are observed, no done
        accept(32'h1234_5678, 1'b0, acc);
        begin
            logic [31:0] v = 32'h1234_5678;
            for (int i = 0; i <= 10; i++) exp_bits.push_back(v[i]);
        end
        do @(negedge clock); while (cyc < acc + 46);
        abort = 1'b1;
        @(posedge clock);
        #1;
        check("abort_start", start_wire, 0);
        check("abort_data", data_wire, 0);
        check("abort_strobe", bit_strobe, 0);
        check("abort_done", done, 0);
        check("abort_ready", tof_if.tof_ready, 1);
        @(negedge clock);
        abort = 1'b0;
        repeat (20) @(negedge clock);
        check("abort_no_resume_start", start_wire, 0);
        check("abort_idle_ready", tof_if.tof_ready, 1);

        // Asynchronous reset during LEAD
        accept(32'h0F0F_0F0F, 1'b0, acc);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_start", start_wire, 0);
        check("reset_async_ready", tof_if.tof_ready, 1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("reset_no_resume_start", start_wire, 0);
        check("reset_idle_ready", tof_if.tof_ready, 1);

        repeat (5) @(negedge clock);
        check("bits_queue_empty", exp_bits.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tof_bit_sender.md
TOF_BIT_SENDER -- requirements
Module: tof_bit_sender

Interface
REQ-001 Parameter BIT_CYCLES, default 10000, clock cycles each serial bit is held on data_wire (minimum 4).
REQ-002 Parameter LEAD_CYCLES, default 100000000, cycles start_wire is high before the first bit is presented (minimum 1).
REQ-003 Parameter NUM_BITS, default 32, number of data bits sent per frame (1..32).
REQ-004 Port clock  input  1  single system clock; all logic is on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port tof_value  input  32  time-of-flight count to send; sampled only on an accepted handshake.
REQ-007 Port tof_valid  input  1  upstream asserts while tof_value is valid.
REQ-008 Port tof_ready  output  1  high only in IDLE; a frame is accepted on a cycle with tof_valid and tof_ready both high.
REQ-009 Port arduino_ack  input  1  asynchronous acknowledge from the Arduino after it has captured a frame.
REQ-010 Port abort  input  1  synchronous request to abandon any frame and return to IDLE.
REQ-011 Port start_wire  output  1  frame envelope to the Arduino; high from acceptance through the last bit period.
REQ-012 Port data_wire  output  1  current serial bit, LSB first.
REQ-013 Port bit_strobe  output  1  high during the second half of every bit period; the Arduino samples data_wire on its rising edge.
REQ-014 Port done  output  1  one-cycle pulse when the last bit period ends.

Function
REQ-015 States SHALL be IDLE, LEAD, SHIFT and WAIT_ACK; any unencoded state value SHALL return to IDLE on the next clock.
REQ-016 IDLE: on handshake, capture tof_value into a 32-bit shift register, set start_wire=1, load the timer with LEAD_CYCLES-1 and enter LEAD on the next edge.
REQ-017 LEAD: decrement the timer each cycle; when it is 0, drive data_wire=shift[0], load the timer with BIT_CYCLES-1, clear the bit counter and enter SHIFT.
REQ-018 SHIFT: hold data_wire for exactly BIT_CYCLES cycles per bit; bit_strobe=1 while timer < BIT_CYCLES/2 (integer division).
REQ-019 SHIFT: when timer=0 and it is not the last bit, shift the register right by one, present the new shift[0], increment the bit counter and reload the timer.
REQ-020 SHIFT: when timer=0 on the last bit, set start_wire=0, data_wire=0 and bit_strobe=0, pulse done for one cycle and enter WAIT_ACK.
REQ-021 Frame length from acceptance to done SHALL be LEAD_CYCLES + NUM_BITS*BIT_CYCLES cycles (+ BIT_CYCLES when parity is enabled).
REQ-022 WAIT_ACK: leave on the first cycle the synchronised arduino_ack is high and enter IDLE; tof_ready rises on the following cycle.
REQ-023 arduino_ack SHALL pass through a two-flop synchroniser before use; latency from the pin to the state change is 2-3 cycles.
REQ-024 tof_valid outside IDLE SHALL be ignored, and tof_value changes during a frame SHALL NOT alter the bits sent.
REQ-025 abort high in any state SHALL force IDLE on the next edge with start_wire, data_wire, bit_strobe and done all 0; abort has priority over a same-cycle handshake, and no frame is accepted that cycle.
REQ-026 If abort and the last-bit timeout coincide, abort SHALL win and done SHALL NOT pulse.
REQ-027 The bit counter and timer SHALL be sized to $clog2 of their maximum counts, and SHALL NOT wrap within a frame.

Reset
REQ-028 On reset, the block SHALL enter IDLE with start_wire=0, data_wire=0, bit_strobe=0, done=0, tof_ready=1 and the shift register, timer, counter and synchroniser all cleared.
REQ-029 If reset is asserted mid-frame, the outputs SHALL clear immediately and the block SHALL NOT resume the frame after reset is released.

Configuration
REQ-030 With macro TOF_SENDER_PARITY_EN defined, one extra bit period SHALL follow the last data bit, carrying the even parity (XOR) of the NUM_BITS captured bits, with done pulsing at its end.
REQ-031 Without TOF_SENDER_PARITY_EN, no parity logic SHALL be present, and the frame SHALL end after the last data bit.

Verification
REQ-032 LEAD_CYCLES=4, BIT_CYCLES=4, NUM_BITS=32, tof_value=0x55555555 -> data_wire reads 1,0,1,0... LSB first; done pulses exactly 132 cycles after acceptance.
REQ-033 Same parameters, tof_value=0x80000001 with TOF_SENDER_PARITY_EN -> first and last data bits are 1, the parity bit is 0, and done pulses at cycle 136.
REQ-034 tof_valid held high throughout, with tof_value changed mid-frame -> only the first value is sent, and tof_ready stays 0 until arduino_ack is seen.
REQ-035 abort pulsed during bit 10 -> all outputs are 0 on the next cycle, no done pulse, tof_ready=1.
REQ-036 reset asserted between clock edges during LEAD -> start_wire falls without a clock edge, and after release the block idles with tof_ready=1.
